// File: rtl/lt_adc_result_reader_if.sv
// Serial link between the result reader and the LT ADC.
// The reader drives chip select, serial clock and serial data in; the converter drives sdout.
interface lt_adc_result_reader_if;
    logic cs;
    logic sclk;
    logic sdin;
    logic sdout;

    modport master (output cs, output sclk, output sdin, input sdout);
    modport slave  (input cs, input sclk, input sdin, output sdout);
endinterface

// File: rtl/lt_adc_result_reader.sv
// Polls the LT ADC end-of-conversion flag, clocks out one 32-bit result frame while
// shifting the config word back in, and presents the decoded result with a valid strobe.
module lt_adc_result_reader #(
    parameter int CLK_DIV  = 5,
    parameter int POLL_LOW = 4,
    parameter int POLL_GAP = 500,
    parameter int TIMEOUT  = 20000
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [31:0]                   cfg_word,
    lt_adc_result_reader_if.master        spi,
    output logic                          out_valid,
    output logic [23:0]                   out_code,
    output logic                          out_sign,
    output logic                          out_ovr,
    output logic                          out_udr,
    output logic                          out_err,
    output logic                          timeout
);

    // state  | meaning
    // IDLE   | link parked, waiting for enable
    // POLL   | cs low, EOC sampled on the last cycle
    // GAP    | cs high between polls / after a frame
    // SHIFT  | 32 sclk periods, full-duplex frame transfer
    // DONE   | one cycle: result registers loaded, out_valid high
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POLL  = 3'd1,
        S_GAP   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int                FAIL_W   = $clog2(TIMEOUT + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(TIMEOUT);
    localparam logic [15:0]       LOW_LOAD = 16'(POLL_LOW - 1);
    localparam logic [15:0]       GAP_LOAD = 16'(POLL_GAP - 1);
    localparam logic [15:0]       DIV_LOAD = 16'(CLK_DIV - 1);

    state_t              state_q, state_d;
    logic [15:0]         timer_q, timer_d;
    logic [4:0]          bit_idx_q, bit_idx_d;
    logic [30:0]         cfg_q, cfg_d;
    logic [30:4]         frame_q, frame_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic                timeout_q, timeout_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                sdin_q, sdin_d;
    logic                valid_q, valid_d;
    logic [23:0]         code_q, code_d;
    logic                sign_q, sign_d;
    logic                ovr_q, ovr_d;
    logic                udr_q, udr_d;
    logic                err_q, err_d;
    logic                timer_tc;

    assign timer_tc = (timer_q == 16'd0);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= 16'd0;
            bit_idx_q <= 5'd0;
            cfg_q     <= '0;
            frame_q   <= '0;
            fail_q    <= '0;
            timeout_q <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            sdin_q    <= 1'b0;
            valid_q   <= 1'b0;
            code_q    <= 24'd0;
            sign_q    <= 1'b0;
            ovr_q     <= 1'b0;
            udr_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            cfg_q     <= cfg_d;
            frame_q   <= frame_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            sdin_q    <= sdin_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            sign_q    <= sign_d;
            ovr_q     <= ovr_d;
            udr_q     <= udr_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_POLL;
            S_POLL:  if (timer_tc) state_d = spi.sdout ? S_GAP : S_SHIFT;
            S_GAP:   if (timer_tc) state_d = enable ? S_POLL : S_IDLE;
            S_SHIFT: if (timer_tc && sclk_q && (bit_idx_q == 5'd0)) state_d = S_DONE;
            S_DONE:  state_d = S_GAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d   = timer_tc ? timer_q : timer_q - 16'd1;
        bit_idx_d = bit_idx_q;
        cfg_d     = cfg_q;
        frame_d   = frame_q;
        fail_d    = fail_q;
        sclk_d    = sclk_q;
        sdin_d    = sdin_q;
        valid_d   = 1'b0;
        code_d    = code_q;
        sign_d    = sign_q;
        ovr_d     = ovr_q;
        udr_d     = udr_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: if (state_d == S_POLL) timer_d = LOW_LOAD;
            S_POLL: begin
                if (timer_tc) begin
                    if (spi.sdout) begin
                        timer_d = GAP_LOAD;
                        if (fail_q != FAIL_MAX) fail_d = fail_q + FAIL_W'(1);
                    end else begin
                        timer_d   = DIV_LOAD;
                        cfg_d     = cfg_word[30:0];
                        bit_idx_d = 5'd31;
                        sdin_d    = cfg_word[31];
                        fail_d    = '0;
                    end
                end
            end
            S_GAP: if (state_d == S_POLL) timer_d = LOW_LOAD;
            S_SHIFT: begin
                if (timer_tc) begin
                    timer_d = DIV_LOAD;
                    sclk_d  = ~sclk_q;
                    if (!sclk_q) begin
                        // Bit 31 is the EOC marker and bits 3:0 carry no result, so only 30:4 are kept.
                        if ((bit_idx_q >= 5'd4) && (bit_idx_q <= 5'd30)) frame_d[bit_idx_q] = spi.sdout;
                    end else if (bit_idx_q != 5'd0) begin
                        bit_idx_d = bit_idx_q - 5'd1;
                        sdin_d    = cfg_q[bit_idx_q - 5'd1];
                    end else begin
                        valid_d = 1'b1;
                        code_d  = frame_q[27:4];
                        sign_d  = frame_q[29];
                        ovr_d   = frame_q[29] & frame_q[28];
                        udr_d   = ~frame_q[29] & ~frame_q[28];
                        err_d   = frame_q[30];
                    end
                end
            end
            S_DONE:  timer_d = GAP_LOAD;
            default: ;
        endcase

        if (state_d != S_SHIFT) begin
            sclk_d = 1'b0;
            sdin_d = 1'b0;
        end
        cs_d      = !((state_d == S_POLL) || (state_d == S_SHIFT));
        timeout_d = timeout_q | (fail_d == FAIL_MAX);
    end

    assign spi.cs    = cs_q;
    assign spi.sclk  = sclk_q;
    assign spi.sdin  = sdin_q;
    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign out_sign  = sign_q;
    assign out_ovr   = ovr_q;
    assign out_udr   = udr_q;
    assign out_err   = err_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_lt_adc_result_reader.sv
// Directed bench for lt_adc_result_reader with a behavioural LT ADC on the serial link.
module tb_lt_adc_result_reader;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] cfg_word = 32'd0;
    logic        out_valid;
    logic [23:0] out_code;
    logic        out_sign, out_ovr, out_udr, out_err, timeout;

    int errors = 0;
    int checks = 0;

    logic        adc_ready = 1'b0;
    logic [31:0] adc_frame = 32'd0;
    logic [31:0] adc_rx = 32'd0;
    int          rise_cnt = 0;
    int          valid_pulses = 0;

    lt_adc_result_reader_if bus ();

    lt_adc_result_reader #(
        .CLK_DIV(2), .POLL_LOW(2), .POLL_GAP(4), .TIMEOUT(3)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .enable(enable), .cfg_word(cfg_word),
        .spi(bus.master), .out_valid(out_valid), .out_code(out_code),
        .out_sign(out_sign), .out_ovr(out_ovr), .out_udr(out_udr),
        .out_err(out_err), .timeout(timeout)
    );

    always #5 sys_clk = ~sys_clk;

    // ADC: frame pointer restarts on cs fall, captures sdin on each sclk rise.
    always @(negedge bus.cs or posedge bus.sclk) begin
        if (!bus.sclk) begin
            rise_cnt = 0;
            adc_rx   = 32'd0;
        end else begin
            rise_cnt = rise_cnt + 1;
            adc_rx   = {adc_rx[30:0], bus.sdin};
        end
    end

    always_comb begin
        if (rise_cnt == 0)       bus.sdout = ~adc_ready;
        else if (rise_cnt < 32)  bus.sdout = adc_frame[31 - rise_cnt];
        else                     bus.sdout = 1'b0;
    end

    always @(negedge sys_clk) if (out_valid === 1'b1) valid_pulses++;

    task automatic wait_valid(input int budget, output int cs_low, output bit got);
        cs_low = 0;
        got    = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (bus.cs === 1'b0) cs_low++;
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs_low(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (bus.cs === 1'b0) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++; if (bus.cs !== 1'b1)     begin errors++; $display("FAIL reset_cs got %b exp 1", bus.cs); end
        checks++; if (bus.sclk !== 1'b0)   begin errors++; $display("FAIL reset_sclk got %b exp 0", bus.sclk); end
        checks++; if (bus.sdin !== 1'b0)   begin errors++; $display("FAIL reset_sdin got %b exp 0", bus.sdin); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_code !== 24'd0 || out_udr !== 1'b0) begin errors++; $display("FAIL reset_fields code %h udr %b exp 0", out_code, out_udr); end
        checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
        rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++; if (bus.cs !== 1'b1)     begin errors++; $display("FAIL idle_cs got %b exp 1", bus.cs); end
    endtask

    task automatic test_frame_latency;
        int low; bit got;
        adc_frame = 32'h2ABCDEF0; cfg_word = 32'hB0500000; adc_ready = 1'b1; valid_pulses = 0;
        enable = 1'b1;
        wait_valid(400, low, got);
        enable = 1'b0;
        checks++; if (got !== 1'b1)        begin errors++; $display("FAIL lat_valid_seen got %b exp 1", got); end
        checks++; if (low != 130)          begin errors++; $display("FAIL lat_cs_low_cycles got %0d exp 130", low); end
        checks++; if (bus.cs !== 1'b1 || bus.sclk !== 1'b0) begin errors++; $display("FAIL lat_done_link cs %b sclk %b exp 1 0", bus.cs, bus.sclk); end
        checks++; if (out_code !== 24'hABCDEF) begin errors++; $display("FAIL lat_code got %h exp abcdef", out_code); end
        checks++; if ({out_sign, out_ovr, out_udr, out_err} !== 4'b1000) begin errors++; $display("FAIL lat_flags got %b exp 1000", {out_sign, out_ovr, out_udr, out_err}); end
        checks++; if (rise_cnt != 32)      begin errors++; $display("FAIL lat_sclk_rises got %0d exp 32", rise_cnt); end
        checks++; if (adc_rx !== 32'hB0500000) begin errors++; $display("FAIL lat_sdin_word got %h exp b0500000", adc_rx); end
        repeat (12) @(negedge sys_clk);
        checks++; if (valid_pulses != 1)   begin errors++; $display("FAIL lat_valid_pulses got %0d exp 1", valid_pulses); end
        checks++; if (out_code !== 24'hABCDEF) begin errors++; $display("FAIL lat_code_hold got %h exp abcdef", out_code); end
    endtask

    task automatic test_underrange;
        int low; bit got;
        adc_frame = 32'h0FFFFFF0; cfg_word = 32'h12345678; adc_ready = 1'b1;
        enable = 1'b1;
        wait_valid(400, low, got);
        enable = 1'b0;
        checks++; if (got !== 1'b1)        begin errors++; $display("FAIL udr_valid_seen got %b exp 1", got); end
        checks++; if (out_code !== 24'hFFFFFF) begin errors++; $display("FAIL udr_code got %h exp ffffff", out_code); end
        checks++; if ({out_sign, out_ovr, out_udr, out_err} !== 4'b0010) begin errors++; $display("FAIL udr_flags got %b exp 0010", {out_sign, out_ovr, out_udr, out_err}); end
        checks++; if (adc_rx !== 32'h12345678) begin errors++; $display("FAIL udr_sdin_word got %h exp 12345678", adc_rx); end
        repeat (12) @(negedge sys_clk);
    endtask

    task automatic test_back_to_back;
        int low; bit got; int hi;
        adc_frame = 32'h30000000; cfg_word = 32'hA5A5A5A5; adc_ready = 1'b1;
        enable = 1'b1;
        wait_valid(400, low, got);
        adc_frame = 32'h40000000;
        checks++; if (got !== 1'b1)        begin errors++; $display("FAIL b2b_first_valid got %b exp 1", got); end
        checks++; if (out_code !== 24'd0 || {out_sign, out_ovr, out_udr, out_err} !== 4'b1100) begin errors++; $display("FAIL b2b_ovr code %h flags %b exp 000000 1100", out_code, {out_sign, out_ovr, out_udr, out_err}); end
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (bus.cs === 1'b0) break;
            hi++;
        end
        checks++; if (hi != 5)             begin errors++; $display("FAIL b2b_cs_high_cycles got %0d exp 5", hi); end
        wait_valid(400, low, got);
        enable = 1'b0;
        checks++; if (got !== 1'b1)        begin errors++; $display("FAIL b2b_second_valid got %b exp 1", got); end
        checks++; if (out_code !== 24'd0 || {out_sign, out_ovr, out_udr, out_err} !== 4'b0011) begin errors++; $display("FAIL b2b_err code %h flags %b exp 000000 0011", out_code, {out_sign, out_ovr, out_udr, out_err}); end
        repeat (12) @(negedge sys_clk);
    endtask

    task automatic test_enable_drop;
        int low; bit got; int lows;
        adc_frame = 32'h3FFFFFF0; cfg_word = 32'h0F0F0F0F; adc_ready = 1'b1; valid_pulses = 0;
        enable = 1'b1;
        wait_cs_low(20);
        for (int i = 0; i < 200; i++) begin
            if (rise_cnt >= 22) break;
            @(negedge sys_clk);
        end
        enable = 1'b0;
        wait_valid(300, low, got);
        checks++; if (got !== 1'b1)        begin errors++; $display("FAIL endrop_valid_seen got %b exp 1", got); end
        checks++; if (out_code !== 24'hFFFFFF || out_ovr !== 1'b1) begin errors++; $display("FAIL endrop_fields code %h ovr %b exp ffffff 1", out_code, out_ovr); end
        lows = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (bus.cs !== 1'b1) lows++;
        end
        checks++; if (lows != 0)           begin errors++; $display("FAIL endrop_cs_idle low cycles %0d exp 0", lows); end
        checks++; if (valid_pulses != 1)   begin errors++; $display("FAIL endrop_valid_pulses got %0d exp 1", valid_pulses); end
    endtask

    task automatic test_timeout;
        logic [17:0] cs_pat; logic tmo13, tmo14; int low; bit got;
        adc_ready = 1'b0; adc_frame = 32'h21234560;
        enable = 1'b1;
        tmo13 = 1'bx; tmo14 = 1'bx;
        for (int i = 0; i < 18; i++) begin
            @(negedge sys_clk);
            cs_pat[i] = bus.cs;
            if (i == 13) tmo13 = timeout;
            if (i == 14) tmo14 = timeout;
        end
        adc_ready = 1'b1;
        checks++; if (cs_pat !== 18'b111100111100111100) begin errors++; $display("FAIL tmo_poll_pattern got %b exp 111100111100111100", cs_pat); end
        checks++; if (tmo13 !== 1'b0)      begin errors++; $display("FAIL tmo_before_third got %b exp 0", tmo13); end
        checks++; if (tmo14 !== 1'b1)      begin errors++; $display("FAIL tmo_after_third got %b exp 1", tmo14); end
        wait_valid(400, low, got);
        enable = 1'b0;
        checks++; if (got !== 1'b1 || out_code !== 24'h123456) begin errors++; $display("FAIL tmo_recover valid %b code %h exp 1 123456", got, out_code); end
        repeat (12) @(negedge sys_clk);
        checks++; if (timeout !== 1'b1)    begin errors++; $display("FAIL tmo_sticky got %b exp 1", timeout); end
    endtask

    task automatic test_reset_mid_shift;
        adc_frame = 32'h2ABCDEF0; cfg_word = 32'hB0500000; adc_ready = 1'b1;
        enable = 1'b1;
        wait_cs_low(20);
        for (int i = 0; i < 200; i++) begin
            if (rise_cnt >= 16) break;
            @(negedge sys_clk);
        end
        rst = 1'b1; enable = 1'b0;
        @(negedge sys_clk);
        checks++; if (bus.cs !== 1'b1 || bus.sclk !== 1'b0) begin errors++; $display("FAIL rstmid_link cs %b sclk %b exp 1 0", bus.cs, bus.sclk); end
        checks++; if (out_valid !== 1'b0 || out_code !== 24'd0) begin errors++; $display("FAIL rstmid_out valid %b code %h exp 0 000000", out_valid, out_code); end
        checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL rstmid_timeout got %b exp 0", timeout); end
        rst = 1'b0; valid_pulses = 0;
        repeat (200) @(negedge sys_clk);
        checks++; if (valid_pulses != 0)   begin errors++; $display("FAIL rstmid_stale_frame pulses %0d exp 0", valid_pulses); end
        checks++; if (bus.cs !== 1'b1)     begin errors++; $display("FAIL rstmid_idle_cs got %b exp 1", bus.cs); end
    endtask

    initial begin
        test_reset();
        test_frame_latency();
        test_underrange();
        test_back_to_back();
        test_enable_drop();
        test_timeout();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
